branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Dynamic branch predictor and EX-stage branch resolver for the 5-stage pipelined CPU. It holds a table of 2-bit saturating counters indexed by PC:
- In IF it predicts each fetched instruction taken or not taken.
- In EX it compares the real outcome of the branch against the prediction carried down the pipeline.
- It produces the 2-bit `Nexttype` code and recovery PC consumed by the hazard/PC-select logic directly downstream.

## Interface
Parameters:
- `BHT_ENTRIES`, 16: number of counters; power of two, 4..256. `IDX = log2(BHT_ENTRIES)`.
- `INIT_STATE`, 2'b01: counter value loaded on reset (weakly not taken).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `IFPC`  in  32  PC of the instruction being fetched.
- `PredTaken`  out  1  prediction for `IFPC`; combinational from the table.
- `IDEXValid`  in  1  EX holds a real instruction (0 = bubble).
- `IDEXBranch`  in  1  EX instruction is a conditional branch.
- `IDEXJump`  in  1  EX instruction is an unconditional jump.
- `IDEXPC`  in  32  PC of the EX instruction.
- `IDEXPredTaken`  in  1  prediction made for the EX instruction when it was fetched.
- `BranchCond`  in  1  resolved branch outcome (1 = taken).
- `IDEXTarget`  in  32  resolved branch/jump target.
- `EXHold`  in  1  EX instruction does not advance this cycle; suppresses the table update.
- `Nexttype`  out  2  `00` PCPlus4, `01` Branch (predicted correctly), `10` BranchWrong, `11` Jump.
- `RecoverPC`  out  32  PC to refetch when `Nexttype` is `10` or `11`.

## Operation
Counter encoding:
- `00` strong NT, `01` weak NT, `10` weak T, `11` strong T.
- Prediction = counter bit 1.

Indexing:
- Read index: `IFPC[IDX+1:2]`. Update index: `IDEXPC[IDX+1:2]`.
- `PredTaken` = bit 1 of `bht[IFPC index]`.
- PC bits [1:0] are ignored.

Resolution (combinational, priority order):
1. `reset` → `Nexttype=00`, `RecoverPC=0`.
2. `!IDEXValid` → `00`.
3. `IDEXJump` → `11`, `RecoverPC=IDEXTarget`. This takes priority even if `IDEXBranch` is also high.
4. `IDEXBranch` with `BranchCond==IDEXPredTaken` → `01`.
5. `IDEXBranch` mismatch, actual taken → `10`, `RecoverPC=IDEXTarget`.
6. `IDEXBranch` mismatch, actual not taken → `10`, `RecoverPC=IDEXPC+4` (32-bit wrap).
7. Otherwise → `00`.
- `RecoverPC` is 0 whenever `Nexttype` is `00` or `01`.

Table update:
- Occurs when `IDEXValid & IDEXBranch & !IDEXJump & !EXHold & !reset`.
- Taken: counter increments, saturating at `11`. Not taken: counter decrements, saturating at `00`.
- Exactly one entry is written per update.
- Jumps and bubbles never modify the table.

## Timing
- `PredTaken`, `Nexttype` and `RecoverPC` are zero-latency combinational outputs. The downstream hazard unit samples them in the same cycle.
- Table writes take effect at the rising edge. A read of the same index in the same cycle returns the old value (no bypass); the new value is visible the next cycle.
- Reset: every entry is loaded with `INIT_STATE` at the first edge with `reset=1`.
  - After reset, `PredTaken = INIT_STATE[1]` (0 by default), `Nexttype=00`, `RecoverPC=0`.
  - Reset during an update cycle discards the update.
- `EXHold` held for N cycles with the same branch in EX produces exactly one update, on the cycle `EXHold` drops.
- Aliasing: PCs that share an index share a counter. This is accepted; there is no tag check.

## Configuration
- `BPU_STATS_EN`: when defined, adds two 32-bit output ports:
  - `BranchCount`: increments on every table update.
  - `MissCount`: increments on every update where `Nexttype==10`.
  - Both reset to 0 synchronously and saturate at `32'hFFFF_FFFF`.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

## Test plan
All scenarios use the defaults (`BHT_ENTRIES=16`).

1. Reset for 1 cycle, then sweep `IFPC` 0x00..0x3C → `PredTaken=0` for all 16 entries; `Nexttype=00`, `RecoverPC=0`.
2. `IDEXValid=1`, `IDEXBranch=1`, `IDEXPC=0x40`, `IDEXPredTaken=0`, `BranchCond=1`, `IDEXTarget=0x80` → `Nexttype=10`, `RecoverPC=0x80` that cycle; next cycle `IFPC=0x40` gives `PredTaken=1` (entry 0 = `10`).
3. From entry 0 = `10`: branch at 0x40, `IDEXPredTaken=1`, `BranchCond=0` → `Nexttype=10`, `RecoverPC=0x44`; entry 0 returns to `01`. Then `IDEXPC=0xFFFF_FFFC` with the same mismatch → `RecoverPC=0x0000_0000`.
4. Four consecutive correct-taken branches at 0x48 with `IDEXPredTaken` following `PredTaken` → `Nexttype` sequence `10,01,01,01`; entry 2 saturates at `11`. Same-cycle read of 0x48 during the first update → old prediction 0.
5. `IDEXJump=1` and `IDEXBranch=1`, `IDEXTarget=0x100` → `Nexttype=11`, `RecoverPC=0x100`, no table change. Mismatching branch with `EXHold=1` for 3 cycles → `Nexttype=10` each cycle, single update after release. `IDEXValid=0` with `IDEXBranch=1` → `Nexttype=00`, no update.
6. With `BPU_STATS_EN`: run scenarios 2–4 → `BranchCount=7`, `MissCount=4`; assert reset → both 0 next cycle.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor (2-bit saturating counters) with EX-stage resolution.
// Define BPU_STATS_EN to add saturating BranchCount / MissCount outputs.
module branch_predict_unit #(
  parameter int         BHT_ENTRIES = 16,
  parameter logic [1:0] INIT_STATE  = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IFPC,
  output logic        PredTaken,
  input  logic        IDEXValid,
  input  logic        IDEXBranch,
  input  logic        IDEXJump,
  input  logic [31:0] IDEXPC,
  input  logic        IDEXPredTaken,
  input  logic        BranchCond,
  input  logic [31:0] IDEXTarget,
  input  logic        EXHold,
  output logic [1:0]  Nexttype,
  output logic [31:0] RecoverPC
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount
`endif
);
  localparam int IDX = $clog2(BHT_ENTRIES);

  localparam logic [1:0] NT_PC4   = 2'b00;
  localparam logic [1:0] NT_BR    = 2'b01;
  localparam logic [1:0] NT_WRONG = 2'b10;
  localparam logic [1:0] NT_JUMP  = 2'b11;

  logic [BHT_ENTRIES-1:0][1:0] bht_q, bht_d;
  logic [IDX-1:0]              rd_idx, wr_idx;
  logic                        upd;
  logic [1:0]                  cur_cnt;

  assign rd_idx    = IFPC[IDX+1:2];
  assign wr_idx    = IDEXPC[IDX+1:2];
  assign PredTaken = bht_q[rd_idx][1];
  assign cur_cnt   = bht_q[wr_idx];

  // Only word-aligned index bits of the PCs reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{IFPC[31:IDX+2], IFPC[1:0], IDEXPC[1:0]};

  always_comb begin
    Nexttype  = NT_PC4;
    RecoverPC = 32'd0;
    if (reset || !IDEXValid) begin
      Nexttype = NT_PC4;
    end else if (IDEXJump) begin
      Nexttype  = NT_JUMP;
      RecoverPC = IDEXTarget;
    end else if (IDEXBranch) begin
      if (BranchCond == IDEXPredTaken) begin
        Nexttype = NT_BR;
      end else begin
        Nexttype  = NT_WRONG;
        RecoverPC = BranchCond ? IDEXTarget : IDEXPC + 32'd4;
      end
    end
  end

  // A held branch stays in EX; it trains the table only on the cycle it leaves.
  assign upd = IDEXValid & IDEXBranch & ~IDEXJump & ~EXHold & ~reset;

  always_comb begin
    bht_d = bht_q;
    if (upd) begin
      if (BranchCond && cur_cnt != 2'b11)
        bht_d[wr_idx] = cur_cnt + 2'd1;
      else if (!BranchCond && cur_cnt != 2'b00)
        bht_d[wr_idx] = cur_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bht_q <= {BHT_ENTRIES{INIT_STATE}};
    else       bht_q <= bht_d;
  end

`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (upd && branch_cnt_q != 32'hFFFF_FFFF)
      branch_cnt_d = branch_cnt_q + 32'd1;
    if (upd && Nexttype == NT_WRONG && miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign BranchCount = branch_cnt_q;
  assign MissCount   = miss_cnt_q;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed + randomized bench for branch_predict_unit against an array-of-ints model.
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IFPC;
  logic        PredTaken;
  logic        IDEXValid, IDEXBranch, IDEXJump, IDEXPredTaken, BranchCond, EXHold;
  logic [31:0] IDEXPC, IDEXTarget;
  logic [1:0]  Nexttype;
  logic [31:0] RecoverPC;
`ifdef BPU_STATS_EN
  logic [31:0] BranchCount, MissCount;
`endif

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .IFPC(IFPC), .PredTaken(PredTaken),
    .IDEXValid(IDEXValid), .IDEXBranch(IDEXBranch), .IDEXJump(IDEXJump),
    .IDEXPC(IDEXPC), .IDEXPredTaken(IDEXPredTaken), .BranchCond(BranchCond),
    .IDEXTarget(IDEXTarget), .EXHold(EXHold), .Nexttype(Nexttype),
    .RecoverPC(RecoverPC)
`ifdef BPU_STATS_EN
    , .BranchCount(BranchCount), .MissCount(MissCount)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int mbht [16];
  bit model_init = 1'b0;
  logic [1:0]  obs_nt;
  logic [31:0] obs_rpc;
  logic        obs_pt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd15);
  endfunction

  function automatic bit mpred(input logic [31:0] pc);
    return mbht[bidx(pc)] >= 2;
  endfunction

  // One cycle: drive, check the combinational outputs against the model, clock, advance model.
  task automatic apply(input bit rst, input bit v, input bit br, input bit jmp,
                       input logic [31:0] pc, input bit pt, input bit cond,
                       input logic [31:0] tgt, input bit hold, input logic [31:0] ifpc);
    logic [1:0]  e_nt;
    logic [31:0] e_rpc;
    reset = rst; IDEXValid = v; IDEXBranch = br; IDEXJump = jmp; IDEXPC = pc;
    IDEXPredTaken = pt; BranchCond = cond; IDEXTarget = tgt; EXHold = hold; IFPC = ifpc;
    #1;
    e_nt = 2'b00; e_rpc = 32'd0;
    if (!rst && v) begin
      if (jmp) begin e_nt = 2'b11; e_rpc = tgt; end
      else if (br) begin
        if (cond == pt) e_nt = 2'b01;
        else begin e_nt = 2'b10; e_rpc = cond ? tgt : pc + 32'd4; end
      end
    end
    obs_nt = Nexttype; obs_rpc = RecoverPC; obs_pt = PredTaken;
    chk("nexttype", {30'd0, Nexttype}, {30'd0, e_nt});
    chk("recoverpc", RecoverPC, e_rpc);
    if (model_init) chk("predtaken", {31'd0, PredTaken}, {31'd0, mpred(ifpc)});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) mbht[i] = 1;
      model_init = 1'b1;
    end else if (v && br && !jmp && !hold) begin
      if (cond) mbht[bidx(pc)] = (mbht[bidx(pc)] == 3) ? 3 : mbht[bidx(pc)] + 1;
      else      mbht[bidx(pc)] = (mbht[bidx(pc)] == 0) ? 0 : mbht[bidx(pc)] - 1;
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] ifpc);
    apply(0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, ifpc);
  endtask

  initial begin
    // Scenario 1: reset, then sweep all entries
    apply(1, 1, 1, 0, 32'h40, 0, 1, 32'h80, 0, 32'h0);
    chk("rst_nt", {30'd0, obs_nt}, 32'd0);
    for (int a = 0; a <= 32'h3C; a += 4) begin
      idle(a);
      chk("sweep_pt", {31'd0, obs_pt}, 32'd0);
    end

    // Scenario 2: mispredicted taken branch at 0x40
    apply(0, 1, 1, 0, 32'h40, 0, 1, 32'h80, 0, 32'h40);
    chk("s2_nt", {30'd0, obs_nt}, 32'd2);
    chk("s2_rpc", obs_rpc, 32'h80);
    idle(32'h40);
    chk("s2_pt", {31'd0, obs_pt}, 32'd1);

    // Scenario 3: mispredicted not-taken, then PC+4 wrap
    apply(0, 1, 1, 0, 32'h40, 1, 0, 32'h80, 0, 32'h0);
    chk("s3_rpc", obs_rpc, 32'h44);
    idle(32'h40);
    chk("s3_pt", {31'd0, obs_pt}, 32'd0);
    apply(0, 1, 1, 0, 32'hFFFF_FFFC, 1, 0, 32'h80, 0, 32'h0);
    chk("s3_wrap_nt", {30'd0, obs_nt}, 32'd2);
    chk("s3_wrap_rpc", obs_rpc, 32'h0);

    // Scenario 4: training entry 2 with prediction fed back
    for (int k = 0; k < 4; k++) begin
      apply(0, 1, 1, 0, 32'h48, mpred(32'h48), 1, 32'h200, 0, 32'h48);
      chk("s4_nt", {30'd0, obs_nt}, (k == 0) ? 32'd2 : 32'd1);
      if (k == 0) chk("s4_nobypass", {31'd0, obs_pt}, 32'd0);
    end
    chk("s4_sat", mbht[2], 3);

    // Scenario 5: jump priority, hold, bubble
    apply(0, 1, 1, 1, 32'h48, 1, 0, 32'h100, 0, 32'h48);
    chk("s5_jnt", {30'd0, obs_nt}, 32'd3);
    chk("s5_jrpc", obs_rpc, 32'h100);
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 1, 0, 32'h50, 0, 1, 32'h300, 1, 32'h50);
      chk("s5_hold_nt", {30'd0, obs_nt}, 32'd2);
      chk("s5_hold_pt", {31'd0, obs_pt}, 32'd0);
    end
    apply(0, 1, 1, 0, 32'h50, 0, 1, 32'h300, 0, 32'h50);
    idle(32'h50);
    chk("s5_rel_pt", {31'd0, obs_pt}, 32'd1);
    apply(0, 1, 1, 0, 32'h50, 1, 0, 32'h300, 0, 32'h50);
    idle(32'h50);
    chk("s5_single_upd", {31'd0, obs_pt}, 32'd0);
    apply(0, 0, 1, 0, 32'h50, 0, 1, 32'h300, 0, 32'h50);
    chk("s5_bubble_nt", {30'd0, obs_nt}, 32'd0);
    idle(32'h50);
    chk("s5_bubble_pt", {31'd0, obs_pt}, 32'd0);

    // Reset during an update must discard it
    apply(1, 1, 1, 0, 32'h48, 1, 0, 32'h0, 0, 32'h48);
    idle(32'h48);
    chk("rst_upd_pt", {31'd0, obs_pt}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {24'd0, 8'($urandom)};
      apply(($urandom_range(0, 60) == 0), ($urandom_range(0, 5) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0), pc,
            ($urandom_range(0, 2) == 0) ? 1'($urandom) : mpred(pc), 1'($urandom),
            $urandom, ($urandom_range(0, 4) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
